// File: rtl/multdiv_unit.sv
// Iterative multiply/divide unit: shift-add multiply, restoring divide, one bit per cycle.
// Signed operands are processed as magnitudes and sign-corrected in a final FIX cycle.
module multdiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             op_q, op_d;
    logic             neg_q, neg_d;
    logic             rneg_q, rneg_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] shf_q, shf_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dz_q, dz_d;

    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_sh;
    logic               rem_ge;
    logic [WIDTH-1:0]   rem_sub;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    // Datapath: acc holds the product high half / partial remainder, shf the
    // multiplier being consumed / dividend bits shifting out as quotient bits shift in.
    always_comb begin
        a_neg    = is_signed & a[WIDTH-1];
        b_neg    = is_signed & b[WIDTH-1];
        a_mag    = a_neg ? -a : a;
        b_mag    = b_neg ? -b : b;
        mul_sum  = {1'b0, acc_q} + (shf_q[0] ? {1'b0, mcand_q} : '0);
        rem_sh   = {acc_q, shf_q[WIDTH-1]};
        rem_ge   = rem_sh >= {1'b0, mcand_q};
        rem_sub  = rem_sh[WIDTH-1:0] - mcand_q;
        prod     = {acc_q, shf_q};
        prod_fix = neg_q ? -prod : prod;
        quo_fix  = neg_q ? -shf_q : shf_q;
        rem_fix  = rneg_q ? -acc_q : acc_q;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        shf_d   = shf_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dz_d    = dz_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    op_d    = op;
                    neg_d   = a_neg ^ b_neg;
                    rneg_d  = a_neg;
                    mcand_d = b_mag;
                    acc_d   = '0;
                    shf_d   = a_mag;
                    cnt_d   = '0;
                    dz_d    = 1'b0;
                    if (op && (b == '0)) begin
                        hi_d    = a;
                        lo_d    = '0;
                        dz_d    = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (op_q) begin
                    acc_d = rem_ge ? rem_sub : rem_sh[WIDTH-1:0];
                    shf_d = {shf_q[WIDTH-2:0], rem_ge};
                end else begin
                    acc_d = mul_sum[WIDTH:1];
                    shf_d = {mul_sum[0], shf_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (op_q) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    {hi_d, lo_d} = prod_fix;
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= 1'b0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            mcand_q <= '0;
            acc_q   <= '0;
            shf_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            shf_q   <= shf_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end

    assign hi       = hi_q;
    assign lo       = lo_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = dz_q;

endmodule
